// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that owns the en/d port of one shared register,
// performing a one-cycle write for the winning requester and then pulsing its ack.
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 7,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_en,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  busy,
    output logic [IDW-1:0]        last_id
);
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("reg_write_arbiter: NREQ must be in 2..8");
    end
    if ((1 << IDW) < NREQ) begin : g_bad_idw
        $error("reg_write_arbiter: IDW too narrow for NREQ");
    end
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [IDW-1:0] ptr, ptr_n, id, id_n, last_n, win, idx;
    logic [NREQ-1:0] gnt_n, ack_n;
    logic [WIDTH-1:0] d_n;
    logic [WIDTH-1:0] wd [NREQ];
    logic en_n, busy_n, found;
    always_comb begin
        for (int i = 0; i < NREQ; i++) wd[i] = wdata[i*WIDTH +: WIDTH];
    end
    // first set request at or after ptr, wrapping modulo NREQ
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ack_n   = ack;
        en_n    = 1'b0;
        d_n     = reg_d;
        busy_n  = busy;
        last_n  = last_id;
        ptr_n   = ptr;
        id_n    = id;
        case (state)
            IDLE: if (found) begin
                state_n = WRITE;
                id_n    = win;
                gnt_n   = NREQ'(1) << win;
                en_n    = 1'b1;
                d_n     = wd[win];
                busy_n  = 1'b1;
            end
            WRITE: begin
                state_n = DONE;
                ack_n   = gnt;
                last_n  = id;
            end
            default: begin
                state_n = IDLE;
                ack_n   = '0;
                gnt_n   = '0;
                busy_n  = 1'b0;
                ptr_n   = (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            ack     <= '0;
            reg_en  <= 1'b0;
            reg_d   <= '0;
            busy    <= 1'b0;
            last_id <= '0;
            ptr     <= '0;
            id      <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            ack     <= ack_n;
            reg_en  <= en_n;
            reg_d   <= d_n;
            busy    <= busy_n;
            last_id <= last_n;
            ptr     <= ptr_n;
            id      <= id_n;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed table-driven bench for reg_write_arbiter (NREQ=4, WIDTH=7),
// with a behavioural model of the shared register fed by reg_en/reg_d.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] wdata = '0;
    logic [3:0]  gnt, ack;
    logic        reg_en;
    logic [6:0]  reg_d, q;
    logic        busy;
    logic [1:0]  last_id;
    int n_checks = 0;
    int n_fail = 0;

    reg_write_arbiter #(.NREQ(4), .WIDTH(7), .IDW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .reg_en(reg_en), .reg_d(reg_d), .busy(busy), .last_id(last_id)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) if (reg_en) q <= reg_d;

    typedef struct {
        logic [3:0]  req;
        logic [27:0] wd;
        logic [3:0]  g, a;
        logic        en;
        logic [6:0]  d;
        logic        b;
        logic [1:0]  l;
    } vec_t;
    vec_t tbl[$];

    localparam logic [27:0] WS = {7'd0, 7'd7, 7'd0, 7'd0};
    localparam logic [27:0] WF = {7'd4, 7'd3, 7'd2, 7'd1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [3:0] r, input logic [27:0] wd, input logic [3:0] g,
                                 input logic [3:0] a, input logic en, input logic [6:0] d,
                                 input logic b, input logic [1:0] l);
        vec_t v;
        v.req = r; v.wd = wd; v.g = g; v.a = a; v.en = en; v.d = d; v.b = b; v.l = l;
        tbl.push_back(v);
    endfunction

    // one full transaction: WRITE cycle, DONE cycle, back in IDLE
    function automatic void xact(input logic [3:0] r, input logic [27:0] wd, input int id,
                                 input logic [6:0] d, input logic [1:0] prev);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        push(r, wd, oh, 4'b0000, 1'b1, d, 1'b1, prev);
        push(r, wd, oh, oh, 1'b0, d, 1'b1, 2'(id));
        push(r, wd, 4'b0000, 4'b0000, 1'b0, d, 1'b0, 2'(id));
    endfunction

    task automatic check_all(input vec_t v, input int i);
        check($sformatf("gnt[%0d]", i), 32'(gnt), 32'(v.g));
        check($sformatf("ack[%0d]", i), 32'(ack), 32'(v.a));
        check($sformatf("reg_en[%0d]", i), 32'(reg_en), 32'(v.en));
        check($sformatf("reg_d[%0d]", i), 32'(reg_d), 32'(v.d));
        check($sformatf("busy[%0d]", i), 32'(busy), 32'(v.b));
        check($sformatf("last_id[%0d]", i), 32'(last_id), 32'(v.l));
    endtask

    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            check("en_single_cycle", 32'(prev_en && reg_en), 32'd0);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        end
        prev_en <= reg_en;
    end

    initial begin
        xact(4'b0100, WS, 2, 7'd7, 2'd0);
        push(4'b0000, WS, 4'b0000, 4'b0000, 1'b0, 7'd7, 1'b0, 2'd2);
        xact(4'b1000, WF, 3, 7'd4, 2'd2);
        xact(4'b1001, WF, 0, 7'd1, 2'd3);
        xact(4'b1000, WF, 3, 7'd4, 2'd0);
        xact(4'b1111, WF, 0, 7'd1, 2'd3);
        xact(4'b1111, WF, 1, 7'd2, 2'd0);
        xact(4'b1111, WF, 2, 7'd3, 2'd1);
        xact(4'b1111, WF, 3, 7'd4, 2'd2);
        xact(4'b1111, WF, 0, 7'd1, 2'd3);
        xact(4'b1111, WF, 1, 7'd2, 2'd0);

        req = 4'b1111;
        wdata = WF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_all('{4'b1111, WF, 4'b0000, 4'b0000, 1'b0, 7'd0, 1'b0, 2'd0}, 100 + i);
        end
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req;
            wdata = tbl[i].wd;
            @(posedge clk); #1;
            check_all(tbl[i], i);
            if (tbl[i].a != 0) check($sformatf("q[%0d]", i), 32'(q), 32'(tbl[i].d));
        end

        // drop request and change data after grant; latched data must still be written
        req = 4'b0010;
        wdata = {7'd4, 7'd3, 7'd9, 7'd1};
        @(posedge clk); #1;
        check("drop_gnt", 32'(gnt), 32'b0010);
        check("drop_en", 32'(reg_en), 32'd1);
        check("drop_d", 32'(reg_d), 32'd9);
        req = 4'b0000;
        wdata = {7'd4, 7'd3, 7'h55, 7'd1};
        @(posedge clk); #1;
        check("drop_ack", 32'(ack), 32'b0010);
        check("drop_en_low", 32'(reg_en), 32'd0);
        check("drop_d_hold", 32'(reg_d), 32'd9);
        check("drop_q", 32'(q), 32'd9);
        check("drop_last", 32'(last_id), 32'd1);
        @(posedge clk); #1;
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_gnt", 32'(gnt), 32'd0);

        // reset in the middle of a write
        req = 4'b1111;
        wdata = WF;
        @(posedge clk); #1;
        check("mid_gnt", 32'(gnt), 32'b0100);
        check("mid_en", 32'(reg_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_en", 32'(reg_en), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_last", 32'(last_id), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        check("post_rst_d", 32'(reg_d), 32'd1);
        check("post_rst_ack", 32'(ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit register between NREQ requesters; the register has a synchronous enable, ports en/d/q.
- Arbitrates write requests round-robin and latches the winner's data.
- Drives the register's en and d for exactly one clock, then returns a one-cycle ack to the winner.
- Sits between the requesting blocks and the shared register; it is the only driver of the register's en and d.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 7, data width of the shared register
- IDW, 2, width of the requester index (equals clog2(NREQ); minimum 1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  NREQ  per-requester write request, level, held until ack
- wdata  input  NREQ*WIDTH  packed write data; requester i owns bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, high for the whole transaction
- ack  output  NREQ  one-hot, one-cycle pulse: the write has been committed
- reg_en  output  1  to the shared register's en
- reg_d  output  WIDTH  to the shared register's d
- busy  output  1  high whenever the state is not IDLE
- last_id  output  IDW  index of the most recently acknowledged requester

Behaviour:
- All outputs are registered.
- Reset (reset=0) takes effect immediately and asynchronously:
  - state=IDLE, gnt=0, ack=0, reg_en=0, reg_d=0, busy=0, last_id=0
  - round-robin pointer ptr=0
- FSM states:
  - IDLE:
    - If req==0, stay in IDLE.
    - Otherwise pick the first set req[i] searching ptr, ptr+1, ... modulo NREQ.
    - Latch the winner index id and wdata[id].
    - Next edge: go to WRITE with gnt=onehot(id), reg_en=1, reg_d=wdata[id], busy=1.
  - WRITE (lasts exactly 1 cycle):
    - The shared register captures reg_d on the edge that leaves WRITE.
    - Next edge: go to DONE with reg_en=0, ack=onehot(id), last_id=id.
    - gnt is held; reg_d holds its value.
  - DONE (lasts exactly 1 cycle):
    - Next edge: go to IDLE with ack=0, gnt=0, busy=0, ptr=(id+1) mod NREQ.
- Timing:
  - Request sampled at edge E0; reg_en is high between E0 and E1; the register loads at E1.
  - ack is high between E1 and E2.
  - Earliest next grant is at E3 (E2 returns to IDLE; IDLE samples req at E3), so sustained throughput is one write per 3 cycles.
- Handshake rules:
  - Requesters hold req and wdata stable until they see ack. Data is latched at grant, so later changes to wdata do not affect the write.
  - A requester that drops req after its grant still gets the write and the ack; there is no abort path.
  - A requester that keeps req high after ack is re-arbitrated in the next IDLE. ptr has already advanced past it, so it has the lowest priority.
- Boundary conditions:
  - Pointer wrap: after serving index NREQ-1, ptr=0.
  - Requests arriving while busy are ignored until IDLE; nothing is queued.
  - reg_en is never high for more than one consecutive cycle.
  - gnt and ack are always one-hot or zero.
  - Reset asserted in WRITE: reg_en drops immediately, no ack is produced, ptr returns to 0.
  - Reset released: the first sampling edge is treated as IDLE.
- Illegal parameters: NREQ outside 2..8 is a compile-time error.

Test Plan (NREQ=4, WIDTH=7):
- Reset: hold reset=0 with req=1111 for 3 cycles -> gnt=0000, ack=0000, reg_en=0, reg_d=0000000, busy=0, last_id=0 throughout.
- Single request: release reset, set req=0100 with wdata[2]=0000111.
  - Edge E0: gnt=0100, reg_en=1, reg_d=0000111.
  - Edge E1: reg_en=0, ack=0100, last_id=2; the register q reads 0000111.
  - Edge E2: gnt=0000, busy=0.
- Fairness: hold req=1111, each wdata[i]=i+1 -> grant order 0,1,2,3,0,1 at 3-cycle spacing; reg_d sequence 1,2,3,4,1,2; every ack pulse lasts 1 cycle.
- Drop and data change: req=0010; drop req[1] and change wdata[1] the cycle after gnt=0010 -> reg_en still pulses with the originally latched data, ack=0010 still pulses.
- Wrap and priority: serve req=1000 alone (ptr becomes 0), then apply req=1001 -> gnt=0001 first, then gnt=1000.
- Reset mid-write: assert reset=0 while reg_en=1 -> reg_en, gnt and busy go 0 before the next clock edge, no ack; after release, req=1111 -> first gnt=0001.
